ir_nec_decoder: RTL and testbench
=================================

IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

Interface
REQ-001 Parameter CLK_DIV, default 50, iCLK cycles per 1 us timing tick.
REQ-002 Parameter ADDR_CHECK, default 1, 1 = address byte must equal ~inverted-address byte for a frame to be accepted.
REQ-003 iCLK  input  1  system clock, single clock domain (CLOCK_50).
REQ-004 iRST  input  1  reset, synchronous, active-high.
REQ-005 iIRDA  input  1  raw IR receiver output, asynchronous, active-low (low = carrier mark).
REQ-006 oREADY  output  1  one-cycle pulse, new valid key on oKEY (drives IR_READY).
REQ-007 oKEY  output  8  last accepted command byte (drives IR_KEY).
REQ-008 oADDR  output  8  last accepted address byte.
REQ-009 oREPEAT  output  1  one-cycle pulse, valid NEC repeat code received.
REQ-010 oERR  output  1  one-cycle pulse, frame aborted (timing or check failure).
REQ-011 oBUSY  output  1  high while state is not IDLE.

Function
REQ-012 iIRDA shall pass through a 2-flop synchronizer plus one edge-detect flop; edges are evaluated on the synchronized signal only.
REQ-013 A prescaler shall count 0..CLK_DIV-1 and issue a 1 us tick; a 14-bit width counter shall increment per tick, saturate at 16383, and clear on every synchronized edge.
REQ-014 States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, CHECK.
REQ-015 IDLE -> LEAD_MARK on falling edge; prescaler and width counter clear.
REQ-016 LEAD_MARK: on rising edge, width 8000..10000 us -> LEAD_SPACE, else oERR, IDLE.
REQ-017 LEAD_SPACE: on falling edge, width 4000..5000 us -> BIT_MARK with bit index 0; width 2000..2500 us -> repeat path; otherwise oERR, IDLE.
REQ-018 Repeat path: if a key has been accepted since reset, pulse oREPEAT and go to IDLE with oKEY/oADDR unchanged; if none, go to IDLE with no pulse.
REQ-019 BIT_MARK: on rising edge, width 400..700 us -> BIT_SPACE, else oERR, IDLE.
REQ-020 BIT_SPACE: on falling edge, width 400..700 us shifts in 0, 1400..1900 us shifts in 1, other widths -> oERR, IDLE; bits shift LSB first into a 32-bit register (addr, ~addr, cmd, ~cmd).
REQ-021 After bit index 31 is shifted -> CHECK; otherwise index increments and -> BIT_MARK.
REQ-022 CHECK (one cycle): cmd == ~cmd_inv and (ADDR_CHECK == 0 or addr == ~addr_inv) -> oKEY/oADDR load, oREADY pulse, key-valid flag set; else oERR; always -> IDLE.
REQ-023 Timeout: in any non-IDLE state, width counter exceeding 10000 us -> oERR, IDLE.
REQ-024 An edge and a timeout in the same cycle: the edge shall take precedence.
REQ-025 oREADY, oREPEAT, oERR shall be registered, mutually exclusive, high for exactly one iCLK cycle.
REQ-026 oREADY latency: no more than 5 iCLK cycles after the iIRDA falling edge ending bit 31's space.
REQ-027 oKEY/oADDR shall change only on an oREADY cycle; a rejected frame leaves them unchanged.
REQ-028 Edges arriving in IDLE other than falling edges shall be ignored.

Reset
REQ-029 iRST high at an iCLK edge: state IDLE, prescaler/width/bit index/shift register 0, key-valid flag 0, synchronizer flops 1, oKEY = oADDR = 0, all pulses and oBUSY 0.
REQ-030 Reset mid-frame shall abort without any oREADY/oREPEAT/oERR pulse; decoding resumes at the next falling edge after iRST deasserts.

Verification
REQ-031 Valid frame addr 0x00, cmd 0x16 (nominal NEC timing) -> one oREADY pulse, oKEY = 0x16, oADDR = 0x00, no oERR.
REQ-032 Repeat code (9 ms mark, 2.25 ms space, 562 us mark) after REQ-031 frame -> one oREPEAT, oKEY stays 0x16; same repeat code after reset -> no pulses.
REQ-033 Frame with cmd 0x16, ~cmd byte 0xE8 -> oERR pulse, oKEY unchanged, no oREADY.
REQ-034 Bit space of 1000 us at bit 5 -> oERR within 5 cycles of that falling edge, IDLE, next good frame decodes normally.
REQ-035 iIRDA held low 12 ms from IDLE -> oERR at 10001 us mark width, oBUSY returns 0.
REQ-036 iRST pulsed at bit 20 of a valid frame -> no pulses, outputs at reset values, following frame addr 0x04 cmd 0x45 -> oREADY, oKEY = 0x45.

Source files
------------

// File: rtl/ir_nec_decoder.sv
// NEC infrared remote decoder: samples the synchronized IR line, measures mark/space
// widths in 1 us ticks, assembles 32-bit frames and reports keys, repeats and errors.
module ir_nec_decoder #(
    parameter int CLK_DIV    = 50,
    parameter bit ADDR_CHECK = 1'b1,
    parameter int TIME_DIV   = 1      // divides every timing window; 1 gives real NEC timing
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iIRDA,
    output logic       oREADY,
    output logic [7:0] oKEY,
    output logic [7:0] oADDR,
    output logic       oREPEAT,
    output logic       oERR,
    output logic       oBUSY
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [13:0] LEAD_MARK_MIN = 14'(8000 / TIME_DIV);
    localparam logic [13:0] LEAD_MARK_MAX = 14'(10000 / TIME_DIV);
    localparam logic [13:0] DATA_SPC_MIN  = 14'(4000 / TIME_DIV);
    localparam logic [13:0] DATA_SPC_MAX  = 14'(5000 / TIME_DIV);
    localparam logic [13:0] REP_SPC_MIN   = 14'(2000 / TIME_DIV);
    localparam logic [13:0] REP_SPC_MAX   = 14'(2500 / TIME_DIV);
    localparam logic [13:0] SHORT_MIN     = 14'(400 / TIME_DIV);
    localparam logic [13:0] SHORT_MAX     = 14'(700 / TIME_DIV);
    localparam logic [13:0] ONE_SPC_MIN   = 14'(1400 / TIME_DIV);
    localparam logic [13:0] ONE_SPC_MAX   = 14'(1900 / TIME_DIV);
    localparam logic [13:0] TIMEOUT       = 14'(10000 / TIME_DIV);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, CHECK
    } state_t;

    state_t        state_q, state_n;
    logic          irda_s1, irda_s2, irda_d;
    logic          fall, rise, edge_any, tick, timeout;
    logic [PW-1:0] pre_q;
    logic [13:0]   width_q;
    logic [4:0]    bit_idx_q, bit_idx_n;
    logic [31:0]   shreg_q, shreg_n;
    logic          key_valid_q;
    logic          ready_n, repeat_n, err_n;

    assign fall     = irda_d & ~irda_s2;
    assign rise     = ~irda_d & irda_s2;
    assign edge_any = fall | rise;
    assign tick     = (pre_q == PW'(CLK_DIV - 1));
    assign timeout  = (width_q > TIMEOUT);

    function automatic logic in_rng(input logic [13:0] w, input logic [13:0] lo,
                                    input logic [13:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            irda_s1     <= 1'b1;
            irda_s2     <= 1'b1;
            irda_d      <= 1'b1;
            pre_q       <= '0;
            width_q     <= '0;
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            key_valid_q <= 1'b0;
            oKEY        <= '0;
            oADDR       <= '0;
            oREADY      <= 1'b0;
            oREPEAT     <= 1'b0;
            oERR        <= 1'b0;
            oBUSY       <= 1'b0;
        end else begin
            irda_s1 <= iIRDA;
            irda_s2 <= irda_s1;
            irda_d  <= irda_s2;
            // Restarting the prescaler on each edge aligns ticks to the measured interval.
            if (edge_any) begin
                pre_q   <= '0;
                width_q <= '0;
            end else begin
                pre_q <= tick ? '0 : pre_q + PW'(1);
                if (tick && (width_q != 14'h3FFF))
                    width_q <= width_q + 14'd1;
            end
            state_q   <= state_n;
            bit_idx_q <= bit_idx_n;
            shreg_q   <= shreg_n;
            oREADY    <= ready_n;
            oREPEAT   <= repeat_n;
            oERR      <= err_n;
            oBUSY     <= (state_n != IDLE);
            if (ready_n) begin
                oKEY        <= shreg_q[23:16];
                oADDR       <= shreg_q[7:0];
                key_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state_q;
        bit_idx_n = bit_idx_q;
        shreg_n   = shreg_q;
        ready_n   = 1'b0;
        repeat_n  = 1'b0;
        err_n     = 1'b0;
        case (state_q)
            IDLE: if (fall) state_n = LEAD_MARK;
            LEAD_MARK: if (rise) begin
                if (in_rng(width_q, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_n = LEAD_SPACE;
                else begin err_n = 1'b1; state_n = IDLE; end
            end
            LEAD_SPACE: if (fall) begin
                if (in_rng(width_q, DATA_SPC_MIN, DATA_SPC_MAX)) begin
                    state_n   = BIT_MARK;
                    bit_idx_n = '0;
                end else if (in_rng(width_q, REP_SPC_MIN, REP_SPC_MAX)) begin
                    repeat_n = key_valid_q;
                    state_n  = IDLE;
                end else begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            BIT_MARK: if (rise) begin
                if (in_rng(width_q, SHORT_MIN, SHORT_MAX)) state_n = BIT_SPACE;
                else begin err_n = 1'b1; state_n = IDLE; end
            end
            BIT_SPACE: if (fall) begin
                if (in_rng(width_q, SHORT_MIN, SHORT_MAX) ||
                    in_rng(width_q, ONE_SPC_MIN, ONE_SPC_MAX)) begin
                    shreg_n = {in_rng(width_q, ONE_SPC_MIN, ONE_SPC_MAX), shreg_q[31:1]};
                    if (bit_idx_q == 5'd31) state_n = CHECK;
                    else begin
                        bit_idx_n = bit_idx_q + 5'd1;
                        state_n   = BIT_MARK;
                    end
                end else begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            CHECK: begin
                if ((shreg_q[23:16] == ~shreg_q[31:24]) &&
                    (!ADDR_CHECK || (shreg_q[7:0] == ~shreg_q[15:8])))
                    ready_n = 1'b1;
                else
                    err_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // An edge in the same cycle wins over the timeout.
        if ((state_q != IDLE) && (state_q != CHECK) && !edge_any && timeout) begin
            err_n   = 1'b1;
            state_n = IDLE;
        end
    end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder; timing windows are scaled down by TIME_DIV=20 and
// one tick is CLK_DIV=2 clocks, so every duration below is in scaled ticks (1 tick = 20 us).
module tb_ir_nec_decoder;

    localparam int CLK_DIV  = 2;
    localparam int TIME_DIV = 20;

    localparam int T_LEAD_M = 450;   // 9 ms
    localparam int T_LEAD_S = 225;   // 4.5 ms
    localparam int T_REP_S  = 112;   // 2.25 ms
    localparam int T_BIT_M  = 28;    // 562 us
    localparam int T_S0     = 28;    // 562 us
    localparam int T_S1     = 84;    // 1687 us
    localparam int T_BAD_S  = 50;    // 1000 us
    localparam int T_GAP    = 150;
    localparam int T_HOLD   = 600;   // 12 ms

    logic       clk = 1'b0;
    logic       rst;
    logic       irda;
    logic       ready, rpt, err, busy;
    logic [7:0] key, addr;

    int n_tests = 0, n_fail = 0;
    int n_ready = 0, n_rep = 0, n_err = 0, n_excl = 0;
    int r0, p0, e0;
    int lat;
    logic [2:0] kind;
    logic busy_mid;

    ir_nec_decoder #(.CLK_DIV(CLK_DIV), .ADDR_CHECK(1'b1), .TIME_DIV(TIME_DIV)) dut (
        .iCLK(clk), .iRST(rst), .iIRDA(irda),
        .oREADY(ready), .oKEY(key), .oADDR(addr),
        .oREPEAT(rpt), .oERR(err), .oBUSY(busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (ready) n_ready <= n_ready + 1;
        if (rpt)   n_rep   <= n_rep + 1;
        if (err)   n_err   <= n_err + 1;
        if (32'(ready) + 32'(rpt) + 32'(err) > 1) n_excl <= n_excl + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        r0 = n_ready; p0 = n_rep; e0 = n_err;
    endtask

    task automatic hold(input logic lvl, input int ticks);
        irda = lvl;
        repeat (ticks * CLK_DIV) @(negedge clk);
    endtask

    // Observe the 8 cycles after an edge; record latency and kind of the first pulse.
    task automatic watch();
        lat  = -1;
        kind = 3'b000;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (lat < 0 && (ready || rpt || err)) begin
                lat  = i;
                kind = {ready, rpt, err};
            end
        end
    endtask

    function automatic logic [31:0] nec_word(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    // Sends lead + bits 0..last_bit; bit bad_idx gets an out-of-window space.
    task automatic send_bits(input logic [31:0] w, input int last_bit, input int bad_idx);
        hold(1'b0, T_LEAD_M);
        hold(1'b1, T_LEAD_S);
        for (int i = 0; i <= last_bit; i++) begin
            hold(1'b0, T_BIT_M);
            hold(1'b1, (i == bad_idx) ? T_BAD_S : (w[i] ? T_S1 : T_S0));
        end
    endtask

    task automatic send_frame(input logic [31:0] w);
        send_bits(w, 31, -1);
        irda = 1'b0;
        watch();
        hold(1'b0, T_BIT_M - 4);
        hold(1'b1, T_GAP);
    endtask

    task automatic send_repeat();
        hold(1'b0, T_LEAD_M);
        hold(1'b1, T_REP_S);
        irda = 1'b0;
        watch();
        hold(1'b0, T_BIT_M - 4);
        hold(1'b1, T_GAP);
    endtask

    initial begin
        rst  = 1'b1;
        irda = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_key", 32'(key), 32'h00);
        check("rst_addr", 32'(addr), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_pulses", {29'b0, ready, rpt, err}, 32'h0);
        rst = 1'b0;
        hold(1'b1, 20);

        snap();
        send_repeat();
        check("rep_norst_pulses", 32'((n_ready - r0) + (n_rep - p0) + (n_err - e0)), 32'd0);

        snap();
        send_frame(nec_word(8'h00, 8'h16));
        check("f1_kind", 32'(kind), 32'b100);
        check("f1_lat_le5", 32'(lat >= 1 && lat <= 5), 32'd1);
        check("f1_ready_cnt", 32'(n_ready - r0), 32'd1);
        check("f1_err_cnt", 32'(n_err - e0), 32'd0);
        check("f1_key", 32'(key), 32'h16);
        check("f1_addr", 32'(addr), 32'h00);
        check("f1_busy", 32'(busy), 32'h0);

        snap();
        send_repeat();
        check("rep_kind", 32'(kind), 32'b010);
        check("rep_cnt", 32'(n_rep - p0), 32'd1);
        check("rep_ready_cnt", 32'(n_ready - r0), 32'd0);
        check("rep_key", 32'(key), 32'h16);

        snap();
        send_frame({8'hE8, 8'h16, 8'hFF, 8'h00});
        check("badcmd_kind", 32'(kind), 32'b001);
        check("badcmd_err_cnt", 32'(n_err - e0), 32'd1);
        check("badcmd_ready_cnt", 32'(n_ready - r0), 32'd0);
        check("badcmd_key", 32'(key), 32'h16);

        snap();
        send_bits(nec_word(8'h10, 8'h22), 5, 5);
        irda = 1'b0;
        watch();
        check("bit5_kind", 32'(kind), 32'b001);
        check("bit5_lat_le5", 32'(lat >= 1 && lat <= 5), 32'd1);
        check("bit5_busy", 32'(busy), 32'h0);
        hold(1'b0, T_BIT_M - 4);
        hold(1'b1, T_GAP);
        check("bit5_err_cnt", 32'(n_err - e0), 32'd1);
        check("bit5_key", 32'(key), 32'h16);

        snap();
        send_frame(nec_word(8'h10, 8'h22));
        check("f2_ready_cnt", 32'(n_ready - r0), 32'd1);
        check("f2_key", 32'(key), 32'h22);
        check("f2_addr", 32'(addr), 32'h10);

        // Mark held low: error when width passes the 10000 us limit (~1006 clocks here).
        snap();
        irda     = 1'b0;
        lat      = -1;
        busy_mid = 1'b0;
        for (int i = 1; i <= T_HOLD * CLK_DIV; i++) begin
            @(negedge clk);
            if (i == 900) busy_mid = busy;
            if (lat < 0 && err) lat = i;
        end
        check("tmo_busy_mid", 32'(busy_mid), 32'h1);
        check("tmo_at_10001us", 32'(lat >= 1004 && lat <= 1008), 32'd1);
        check("tmo_busy_after", 32'(busy), 32'h0);
        hold(1'b1, T_GAP);
        check("tmo_err_cnt", 32'(n_err - e0), 32'd1);
        check("tmo_key", 32'(key), 32'h22);

        snap();
        send_bits(nec_word(8'h04, 8'h45), 19, -1);
        hold(1'b0, T_BIT_M);
        hold(1'b1, 10);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, T_GAP);
        check("midrst_pulses", 32'((n_ready - r0) + (n_rep - p0) + (n_err - e0)), 32'd0);
        check("midrst_key", 32'(key), 32'h00);
        check("midrst_addr", 32'(addr), 32'h00);
        check("midrst_busy", 32'(busy), 32'h0);

        snap();
        send_frame(nec_word(8'h04, 8'h45));
        check("f3_ready_cnt", 32'(n_ready - r0), 32'd1);
        check("f3_key", 32'(key), 32'h45);
        check("f3_addr", 32'(addr), 32'h04);

        check("pulse_excl", 32'(n_excl), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
